// File: rtl/lock_controller_if.sv
// lock_controller_if: keypad, checker and status signals of the lock controller.
// The slave modport is the controller's view. The master modport is the
// environment's view: the keypad and the code checker that the controller drives.
interface lock_controller_if;
  logic       key_valid;
  logic [1:0] key_bits;
  logic       enter;
  logic       program_mode;
  logic       correct_password;
  logic       incorrect_password;
  logic [1:0] bits;
  logic       input_value;
  logic       store_value;
  logic       compare;
  logic       input_reset;
  logic       unlocked;
  logic       locked_out;
  logic       code_set;
  logic       checker_rst_n;

  modport slave (
    input  key_valid, key_bits, enter, program_mode,
           correct_password, incorrect_password,
    output bits, input_value, store_value, compare, input_reset,
           unlocked, locked_out, code_set, checker_rst_n
  );

  modport master (
    output key_valid, key_bits, enter, program_mode,
           correct_password, incorrect_password,
    input  bits, input_value, store_value, compare, input_reset,
           unlocked, locked_out, code_set, checker_rst_n
  );
endinterface

// File: rtl/lock_controller.sv
// lock_controller: sequences keypad presses into an external code checker.
// It programs the system code, forwards entered digits, requests a compare,
// and opens the lock or counts a failed attempt.
// Build option: define LOCK_CONTROLLER_LOCKOUT_EN to add the failed-attempt
// counter and the LOCKOUT state. Without it, a failed compare always goes to
// CLEAR and locked_out is tied low.
module lock_controller #(
  parameter int MAX_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES  = 500
) (
  input  logic             clk,
  input  logic             system_reset,
  lock_controller_if.slave bus
);

  localparam int DCW  = $clog2(MAX_DIGITS + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DCW-1:0] DIGIT_LIMIT = DCW'(MAX_DIGITS);
  localparam logic [TW-1:0]  TIMER_SAT   = TW'(TMAX);
  localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
  localparam int             ACW           = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [ACW-1:0] ATTEMPT_LIMIT = ACW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0]  LOCKOUT_LAST  = TW'(LOCKOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_PROGRAM,
    S_CMP,
    S_WAIT,
    S_OPEN,
    S_CLEAR
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [1:0]     r_bits;
  logic           r_input_value;
  logic           r_store_value;
  logic           r_code_set;
  logic [DCW-1:0] r_digits;
  logic [TW-1:0]  r_timer;
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
  logic [ACW-1:0] r_attempts;
  logic [ACW-1:0] w_attempts_next;
  logic           w_fail;
`endif

  logic w_key;
  logic w_room;
  logic w_result_ok;
  logic w_wait_done;
  logic w_take_input;
  logic w_take_store;
  logic w_set_code;

  // A key pressed together with enter is dropped, because enter wins.
  assign w_key       = bus.key_valid & ~bus.enter;
  assign w_room      = (r_digits < DIGIT_LIMIT);
  // Only correct=1 with incorrect=0 counts as a match. Any other mix is a failure.
  assign w_result_ok = bus.correct_password & ~bus.incorrect_password;
  // The dwell timer restarts on entry to WAIT, so a nonzero value means the
  // second WAIT cycle, where the checker result is sampled.
  assign w_wait_done = (r_timer != '0);

`ifdef LOCK_CONTROLLER_LOCKOUT_EN
  assign w_attempts_next = (r_attempts != ATTEMPT_LIMIT) ? r_attempts + ACW'(1) : r_attempts;
  assign w_fail          = (r_state == S_WAIT) && w_wait_done && !w_result_ok;
`endif

  // Next-state logic and key acceptance decisions.
  always_comb begin
    w_next_state = r_state;
    w_take_input = 1'b0;
    w_take_store = 1'b0;
    w_set_code   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key && w_room && r_code_set) begin
          w_next_state = S_ENTRY;
          w_take_input = 1'b1;
        end else if (w_key && w_room && bus.program_mode) begin
          w_next_state = S_PROGRAM;
          w_take_store = 1'b1;
        end
      end
      S_ENTRY: begin
        if (bus.enter) begin
          if (r_digits != '0) begin
            w_next_state = S_CMP;
          end
        end else if (bus.key_valid && w_room) begin
          w_take_input = 1'b1;
        end
      end
      S_PROGRAM: begin
        if (bus.enter) begin
          if (r_digits != '0) begin
            w_set_code   = 1'b1;
            w_next_state = S_CLEAR;
          end
        end else if (bus.key_valid && w_room) begin
          w_take_store = 1'b1;
        end
      end
      S_CMP: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_done) begin
          if (w_result_ok) begin
            w_next_state = S_OPEN;
          end else begin
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
            if (w_attempts_next >= ATTEMPT_LIMIT) begin
              w_next_state = S_LOCKOUT;
            end else begin
              w_next_state = S_CLEAR;
            end
`else
            w_next_state = S_CLEAR;
`endif
          end
        end
      end
      S_OPEN: begin
        if (bus.enter || (r_timer >= UNLOCK_LAST)) begin
          w_next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next_state = S_IDLE;
      end
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
      S_LOCKOUT: begin
        if (r_timer >= LOCKOUT_LAST) begin
          w_next_state = S_CLEAR;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the accepted digit and raise its one-cycle strobe on the next cycle.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_bits        <= 2'b00;
      r_input_value <= 1'b0;
      r_store_value <= 1'b0;
    end else begin
      r_input_value <= w_take_input;
      r_store_value <= w_take_store;
      if (w_take_input || w_take_store) begin
        r_bits <= bus.key_bits;
      end
    end
  end

  // Count digits in the current entry, saturating. CLEAR zeroes the count.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_digits <= '0;
    end else if (r_state == S_CLEAR) begin
      r_digits <= '0;
    end else if ((w_take_input || w_take_store) && (r_digits != DIGIT_LIMIT)) begin
      r_digits <= r_digits + DCW'(1);
    end
  end

  // Sticky flag: a system code has been programmed since reset.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_code_set <= 1'b0;
    end else if (w_set_code) begin
      r_code_set <= 1'b1;
    end
  end

  // Shared dwell timer for WAIT, OPEN and LOCKOUT. It restarts on every state change.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_timer <= '0;
    end else if (r_state != w_next_state) begin
      r_timer <= '0;
    end else if (r_timer != TIMER_SAT) begin
      r_timer <= r_timer + TW'(1);
    end
  end

`ifdef LOCK_CONTROLLER_LOCKOUT_EN
  // Consecutive failure counter. A match or the end of a lockout clears it.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_attempts <= '0;
    end else if ((r_state == S_WAIT) && (w_next_state == S_OPEN)) begin
      r_attempts <= '0;
    end else if ((r_state == S_LOCKOUT) && (w_next_state != S_LOCKOUT)) begin
      r_attempts <= '0;
    end else if (w_fail) begin
      r_attempts <= w_attempts_next;
    end
  end

  assign bus.locked_out = (r_state == S_LOCKOUT);
`else
  assign bus.locked_out = 1'b0;
`endif

  assign bus.bits          = r_bits;
  assign bus.input_value   = r_input_value;
  assign bus.store_value   = r_store_value;
  assign bus.compare       = (r_state == S_CMP);
  assign bus.input_reset   = (r_state != S_CLEAR);
  assign bus.unlocked      = (r_state == S_OPEN);
  assign bus.code_set      = r_code_set;
  assign bus.checker_rst_n = system_reset;

endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed checks of the lock controller with default parameters.
// It covers both builds: the lockout checks follow LOCK_CONTROLLER_LOCKOUT_EN.
module tb_lock_controller;
  logic clk;
  logic systemReset;

  int total = 0;
  int bad   = 0;

  int cntInput    = 0;
  int cntStore    = 0;
  int cntCompare  = 0;
  int cntClear    = 0;
  int cntUnlocked = 0;
  int cntLocked   = 0;
  logic [1:0] storeLog[$];

  int i0, s0, k0, u0, c0, l0, lat;

  lock_controller_if bus();

  lock_controller #(
    .MAX_DIGITS(4),
    .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(1000),
    .UNLOCK_CYCLES(500)
  ) dut (
    .clk(clk),
    .system_reset(systemReset),
    .bus(bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count strobe and status cycles on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.input_value === 1'b1) cntInput++;
    if (bus.store_value === 1'b1) begin
      storeLog.push_back(bus.bits);
      cntStore++;
    end
    if (bus.compare === 1'b1) cntCompare++;
    if (bus.input_reset === 1'b0) cntClear++;
    if (bus.unlocked === 1'b1) cntUnlocked++;
    if (bus.locked_out === 1'b1) cntLocked++;
  end

  // Compare one observed value against its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of keypad inputs, then release them at the next falling edge.
  task automatic applyStimulus(input logic kv, input logic [1:0] kb, input logic en);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_bits  = kb;
    bus.enter     = en;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.enter     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count falling edges until unlocked rises, with a bound on the wait.
  task automatic waitUnlocked(output int cycles);
    cycles = 0;
    while (bus.unlocked !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Stop the run if it overruns its time budget.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    bus.key_valid          = 1'b0;
    bus.key_bits           = 2'd0;
    bus.enter              = 1'b0;
    bus.program_mode       = 1'b0;
    bus.correct_password   = 1'b0;
    bus.incorrect_password = 1'b0;
    systemReset            = 1'b1;
    #2 systemReset = 1'b0;
    idle(2);

    // Reset values.
    checkOutput("rst_bits", int'(bus.bits), 0);
    checkOutput("rst_input_value", int'(bus.input_value), 0);
    checkOutput("rst_store_value", int'(bus.store_value), 0);
    checkOutput("rst_compare", int'(bus.compare), 0);
    checkOutput("rst_input_reset", int'(bus.input_reset), 1);
    checkOutput("rst_unlocked", int'(bus.unlocked), 0);
    checkOutput("rst_locked_out", int'(bus.locked_out), 0);
    checkOutput("rst_code_set", int'(bus.code_set), 0);
    checkOutput("rst_checker_fwd", int'(bus.checker_rst_n), 0);
    systemReset = 1'b1;
    idle(2);
    checkOutput("checker_fwd_high", int'(bus.checker_rst_n), 1);

    // With no code and program_mode low, keys are ignored.
    s0 = cntStore; i0 = cntInput;
    applyStimulus(1'b1, 2'd2, 1'b0);
    idle(3);
    checkOutput("unprog_store", cntStore - s0, 0);
    checkOutput("unprog_input", cntInput - i0, 0);
    checkOutput("unprog_bits", int'(bus.bits), 0);

    // Program the code 1,2,3 and press enter.
    bus.program_mode = 1'b1;
    s0 = cntStore; i0 = cntInput; c0 = cntClear;
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("prog_strobe", int'(bus.store_value), 1);
    checkOutput("prog_bits", int'(bus.bits), 1);
    @(negedge clk);
    checkOutput("prog_strobe_width", int'(bus.store_value), 0);
    checkOutput("prog_bits_hold", int'(bus.bits), 1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("prog_clear_low", int'(bus.input_reset), 0);
    idle(3);
    bus.program_mode = 1'b0;
    checkOutput("prog_store_count", cntStore - s0, 3);
    checkOutput("prog_log0", (storeLog.size() > s0) ? int'(storeLog[s0]) : -1, 1);
    checkOutput("prog_log1", (storeLog.size() > s0 + 1) ? int'(storeLog[s0+1]) : -1, 2);
    checkOutput("prog_log2", (storeLog.size() > s0 + 2) ? int'(storeLog[s0+2]) : -1, 3);
    checkOutput("prog_code_set", int'(bus.code_set), 1);
    checkOutput("prog_clear_count", cntClear - c0, 1);
    checkOutput("prog_input_count", cntInput - i0, 0);

    // Correct entry. program_mode is high but is ignored once a code is set.
    bus.program_mode       = 1'b1;
    bus.correct_password   = 1'b1;
    bus.incorrect_password = 1'b0;
    i0 = cntInput; s0 = cntStore; k0 = cntCompare; u0 = cntUnlocked; c0 = cntClear;
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("entry_strobe", int'(bus.input_value), 1);
    checkOutput("entry_bits", int'(bus.bits), 1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("entry_compare", int'(bus.compare), 1);
    waitUnlocked(lat);
    checkOutput("unlock_latency", lat, 3);
    idle(510);
    bus.program_mode = 1'b0;
    checkOutput("open_ended", int'(bus.unlocked), 0);
    checkOutput("open_cycles", cntUnlocked - u0, 500);
    checkOutput("entry_input_count", cntInput - i0, 3);
    checkOutput("entry_store_count", cntStore - s0, 0);
    checkOutput("entry_compare_count", cntCompare - k0, 1);
    checkOutput("open_clear_count", cntClear - c0, 1);

    // Enter while open closes the lock early.
    u0 = cntUnlocked;
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    waitUnlocked(lat);
    checkOutput("reopen", int'(bus.unlocked), 1);
    idle(9);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("open_enter_exit", int'(bus.unlocked), 0);
    idle(3);
    checkOutput("open_enter_cycles", cntUnlocked - u0, 11);

    // Failure 1: six keys, only four forwarded, checker reports incorrect.
    bus.correct_password   = 1'b0;
    bus.incorrect_password = 1'b1;
    i0 = cntInput; k0 = cntCompare; u0 = cntUnlocked;
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 2'(k % 4), 1'b0);
    checkOutput("drop_bits_hold", int'(bus.bits), 3);
    applyStimulus(1'b0, 2'd0, 1'b1);
    idle(8);
    checkOutput("drop_input_count", cntInput - i0, 4);
    checkOutput("drop_compare_count", cntCompare - k0, 1);
    checkOutput("fail1_unlocked", cntUnlocked - u0, 0);
    checkOutput("fail1_locked_out", int'(bus.locked_out), 0);

    // Failure 2: key and enter together after two digits. Both results high.
    bus.correct_password   = 1'b1;
    bus.incorrect_password = 1'b1;
    i0 = cntInput; k0 = cntCompare; u0 = cntUnlocked;
    applyStimulus(1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1);
    checkOutput("simul_no_strobe", int'(bus.input_value), 0);
    checkOutput("simul_compare", int'(bus.compare), 1);
    checkOutput("simul_bits", int'(bus.bits), 2);
    idle(6);
    checkOutput("simul_input_count", cntInput - i0, 2);
    checkOutput("simul_compare_count", cntCompare - k0, 1);
    checkOutput("both_high_unlocked", cntUnlocked - u0, 0);

    // Failure 3: both results low.
    bus.correct_password   = 1'b0;
    bus.incorrect_password = 1'b0;
    i0 = cntInput; k0 = cntCompare; c0 = cntClear; l0 = cntLocked;
    applyStimulus(1'b1, 2'd1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
`ifdef LOCK_CONTROLLER_LOCKOUT_EN
    lat = 0;
    while (bus.locked_out !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("lock_assert", int'(bus.locked_out), 1);
    applyStimulus(1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1);
    lat = 0;
    while (bus.locked_out === 1'b1 && lat < 1100) begin
      @(negedge clk);
      lat++;
    end
    idle(3);
    checkOutput("lock_released", int'(bus.locked_out), 0);
    checkOutput("lock_cycles", cntLocked - l0, 1000);
    checkOutput("lock_keys_ignored", cntInput - i0, 1);
    checkOutput("lock_enter_ignored", cntCompare - k0, 1);
    checkOutput("lock_clear_count", cntClear - c0, 1);
`else
    idle(20);
    checkOutput("nolock_locked_out", int'(bus.locked_out), 0);
    checkOutput("nolock_cycles", cntLocked - l0, 0);
    checkOutput("nolock_clear_count", cntClear - c0, 1);
    checkOutput("nolock_compare_count", cntCompare - k0, 1);
`endif

    // Back in IDLE, a key is accepted. Reset in WAIT then aborts everything.
    bus.correct_password   = 1'b1;
    bus.incorrect_password = 1'b0;
    applyStimulus(1'b1, 2'd1, 1'b0);
    checkOutput("idle_key_accepted", int'(bus.input_value), 1);
    applyStimulus(1'b0, 2'd0, 1'b1);
    checkOutput("wait_compare", int'(bus.compare), 1);
    @(negedge clk);
    #1 systemReset = 1'b0;
    #1;
    checkOutput("abort_compare", int'(bus.compare), 0);
    checkOutput("abort_input_value", int'(bus.input_value), 0);
    checkOutput("abort_unlocked", int'(bus.unlocked), 0);
    checkOutput("abort_input_reset", int'(bus.input_reset), 1);
    checkOutput("abort_code_set", int'(bus.code_set), 0);
    checkOutput("abort_bits", int'(bus.bits), 0);
    checkOutput("abort_locked_out", int'(bus.locked_out), 0);
    idle(2);
    systemReset = 1'b1;
    i0 = cntInput; s0 = cntStore; k0 = cntCompare; u0 = cntUnlocked;
    idle(10);
    checkOutput("post_rst_compare", cntCompare - k0, 0);
    checkOutput("post_rst_input", cntInput - i0, 0);
    checkOutput("post_rst_store", cntStore - s0, 0);
    checkOutput("post_rst_unlocked", cntUnlocked - u0, 0);
    checkOutput("post_rst_code_set", int'(bus.code_set), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter MAX_DIGITS, default 4; max code digits forwarded per entry.
REQ-002 Parameter MAX_ATTEMPTS, default 3; consecutive failures before lockout.
REQ-003 Parameter LOCKOUT_CYCLES, default 1000; lockout duration in clk cycles.
REQ-004 Parameter UNLOCK_CYCLES, default 500; unlocked hold time in clk cycles.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 system_reset  in  1  asynchronous, active-low reset; also forwarded unchanged to the checker.
REQ-007 key_valid  in  1  one-cycle keypad press strobe.
REQ-008 key_bits  in  2  keypad digit, valid with key_valid.
REQ-009 enter  in  1  one-cycle enter-key strobe.
REQ-010 program_mode  in  1  level; 1 = store keys as the system code.
REQ-011 correct_password, incorrect_password  in  1 each  checker result levels.
REQ-012 bits  out  2  digit to checker.
REQ-013 input_value, store_value, compare  out  1 each  one-cycle high strobes to checker.
REQ-014 input_reset  out  1  active-low one-cycle pulse clearing the checker's entered code.
REQ-015 unlocked  out  1  lock open.
REQ-016 locked_out  out  1  lockout active.
REQ-017 code_set  out  1  system code has been programmed since reset.

Function
REQ-018 States SHALL be IDLE, ENTRY, PROGRAM, CMP, WAIT, OPEN, CLEAR, LOCKOUT.
REQ-019 On accepted key, bits SHALL load key_bits that edge; the strobe SHALL assert the following cycle for exactly one cycle; bits SHALL hold until the next accepted key.
REQ-020 IDLE: key_valid with program_mode=1 and code_set=0 -> PROGRAM (key accepted); key_valid with code_set=1 -> ENTRY (key accepted); all other keys ignored.
REQ-021 ENTRY: each key SHALL raise input_value; keys beyond MAX_DIGITS SHALL be dropped with no strobe.
REQ-022 PROGRAM: each key SHALL raise store_value, same MAX_DIGITS limit; enter with >=1 digit SHALL set code_set and go to CLEAR.
REQ-023 ENTRY enter with >=1 digit -> CMP; enter with 0 digits ignored.
REQ-024 CMP: compare high one cycle, then WAIT; result sampled on the 2nd cycle of WAIT.
REQ-025 Result correct=1, incorrect=0 -> OPEN, clear attempt counter; any other combination, including both high or both low, counts as failure.
REQ-026 OPEN: unlocked=1 for UNLOCK_CYCLES or until enter, then CLEAR.
REQ-027 Failure -> increment attempts; CLEAR; or LOCKOUT when attempts reaches MAX_ATTEMPTS.
REQ-028 CLEAR: input_reset low one cycle, digit count zeroed, then IDLE.
REQ-029 LOCKOUT: locked_out=1, all keys/enter ignored for LOCKOUT_CYCLES, then attempts=0 and CLEAR.
REQ-030 key_valid and enter in the same cycle: enter SHALL take priority and the key SHALL be dropped.
REQ-031 Counters SHALL saturate, never wrap; digit count width ceil(log2(MAX_DIGITS+1)).
REQ-032 Program_mode changes outside IDLE SHALL have no effect.

Reset
REQ-033 On system_reset low: state IDLE, bits=0, input_value=store_value=compare=0, input_reset=1, unlocked=0, locked_out=0, code_set=0, all counters 0.
REQ-034 Reset mid-operation SHALL abort immediately with no strobe emitted on release.

Configuration
REQ-035 Macro LOCK_CONTROLLER_LOCKOUT_EN defined: attempt counter and LOCKOUT state as above.
REQ-036 Macro undefined: no attempt counter or LOCKOUT state, failure always -> CLEAR, locked_out tied 0.

Verification
REQ-037 Reset, program 1,2,3 + enter -> three store_value pulses with bits 1,2,3; code_set=1; one input_reset pulse.
REQ-038 Enter 1,2,3 + enter, checker correct -> three input_value pulses, one compare, unlocked=1 for 500 cycles.
REQ-039 Enter 6 keys (MAX_DIGITS=4) -> exactly 4 input_value pulses.
REQ-040 Three wrong codes (LOCKOUT_EN) -> locked_out=1 for 1000 cycles, keys ignored, then IDLE; without macro, no lockout.
REQ-041 key_valid and enter same cycle in ENTRY with 2 digits -> no input_value, compare pulse follows.
REQ-042 Assert reset during WAIT -> all outputs at reset values, no compare or strobe after release.
